// File: rtl/ddr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ddr_ctrl_pkg
// Shared definitions for the DDR local-interface adapter:
//   - state_t      : state encoding of the access sequencer
//   - count_t      : width of the word/beat counters (covers 2^15 words)
//   - chunk_size() : size of the next local burst, capped at the largest burst
// ---------------------------------------------------------------------------
package ddr_ctrl_pkg;

  localparam int MAX_BURST_LOG2_DEF = 4;

  // buf_width is 4 bits, so a read is at most 2^15 words; 16 bits holds that.
  localparam int REM_WIDTH = 16;

  typedef logic [REM_WIDTH-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RECOVER
  } state_t;

  // Next local burst length: whatever is left, but never more than one
  // maximum-size burst.
  function automatic count_t chunk_size(input count_t remaining,
                                        input int unsigned max_burst_log2);
    count_t max_burst;
    max_burst = count_t'(1) << max_burst_log2;
    return (remaining > max_burst) ? max_burst : remaining;
  endfunction

endpackage

// File: rtl/ddr_local_if_if.sv
// ---------------------------------------------------------------------------
// ddr_local_bus_if
// Avalon-style local interface of the Altera DDR controller.
//   master : the adapter (drives requests, receives ready / read data)
//   slave  : the controller (or its model)
// Signals:
//   init_done   calibration complete
//   ready       controller accepts the request this cycle
//   address     word address
//   read_req / write_req / burstbegin
//   size        beats in the burst
//   be / wdata  write byte enables / write data
//   rdata / rdata_valid  read data return
// ---------------------------------------------------------------------------
interface ddr_local_bus_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int SIZE_WIDTH = 5
);

  logic                  init_done;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] address;
  logic                  read_req;
  logic                  write_req;
  logic                  burstbegin;
  logic [SIZE_WIDTH-1:0] size;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  rdata_valid;

  modport master (
    input  init_done, ready, rdata, rdata_valid,
    output address, read_req, write_req, burstbegin, size, be, wdata
  );

  modport slave (
    output init_done, ready, rdata, rdata_valid,
    input  address, read_req, write_req, burstbegin, size, be, wdata
  );

endinterface

// File: rtl/ddr_local_if.sv
// ---------------------------------------------------------------------------
// ddr_local_if
// Translates the wishbone arbiter's internal access (one write word, or a
// 2^buf_width-word aligned read) into local-interface requests for the DDR
// controller, and returns one ack per word with its byte address and data.
// Ports (sdram_clk domain):
//   sdram_clk, sdram_rst_n      clock, asynchronous active-low reset
//   acc_i, we_i, adr_i, dat_i,  access request from the arbiter
//   sel_i, buf_width_i
//   ack_o, adr_o, dat_o         per-word acknowledge, byte address, read data
//   idle_o                      ready for a new access (arbiter may switch)
//   local_bus                   controller local interface (master side)
// Reads are split into bursts of at most 2^MAX_BURST_LOG2 words, with exactly
// one burst outstanding. Data returns sequentially from the aligned base.
// ---------------------------------------------------------------------------
module ddr_local_if
  import ddr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int MAX_BURST_LOG2 = MAX_BURST_LOG2_DEF,
  parameter int SIZE_WIDTH     = MAX_BURST_LOG2 + 1
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst_n,

  input  logic                   acc_i,
  input  logic                   we_i,
  input  logic [31:0]            adr_i,
  input  logic [31:0]            dat_i,
  input  logic [3:0]             sel_i,
  input  logic [3:0]             buf_width_i,

  output logic                   ack_o,
  output logic [31:0]            adr_o,
  output logic [31:0]            dat_o,
  output logic                   idle_o,

  ddr_local_bus_if.master        local_bus
);

  state_t                state_q, state_d;

  logic [ADDR_WIDTH-1:0] word_q;       // current word address
  count_t                remaining_q;  // words not yet requested
  count_t                beats_q;      // beats left in the outstanding burst
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic                  ack_q;
  logic [31:0]           adr_q;
  logic [31:0]           rdata_q;

  logic                  start;
  logic [ADDR_WIDTH-1:0] align_mask;
  count_t                chunk;
  logic                  wr_req, rd_req;
  logic [SIZE_WIDTH-1:0] size;

  // The byte-offset bits and the bits above the local address range do not
  // select a DDR word.
  logic unused_adr;
  assign unused_adr = ^{adr_i[31:ADDR_WIDTH+2], adr_i[1:0]};

  assign start = acc_i && local_bus.init_done;

  // Reads start at a 2^buf_width-aligned word; writes keep the full address.
  assign align_mask = we_i ? {ADDR_WIDTH{1'b1}}
                           : ({ADDR_WIDTH{1'b1}} << buf_width_i);

  assign chunk = chunk_size(remaining_q, MAX_BURST_LOG2);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next state and request outputs
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idle_o  = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    size    = '0;

    unique case (state_q)
      ST_IDLE: begin
        idle_o = local_bus.init_done;
        if (start) state_d = we_i ? ST_WR_REQ : ST_RD_REQ;
      end

      ST_WR_REQ: begin
        wr_req = 1'b1;
        size   = SIZE_WIDTH'(1);
        if (local_bus.ready) state_d = ST_RECOVER;
      end

      ST_RD_REQ: begin
        rd_req = 1'b1;
        size   = chunk[SIZE_WIDTH-1:0];
        if (local_bus.ready) state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        // remaining_q was already reduced by this burst when it was accepted.
        if (local_bus.rdata_valid && beats_q == count_t'(1))
          state_d = (remaining_q != '0) ? ST_RD_REQ : ST_RECOVER;
      end

      // One dead cycle so the requester can drop acc_i after its final ack.
      ST_RECOVER: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: latched access, address / burst counters, ack return
  // -------------------------------------------------------------------------
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      word_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      adr_q       <= '0;
      rdata_q     <= '0;
    end else begin
      ack_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q       <= sel_i;
            wdata_q     <= dat_i;
            word_q      <= adr_i[ADDR_WIDTH+1:2] & align_mask;
            remaining_q <= we_i ? count_t'(1) : (count_t'(1) << buf_width_i);
          end
        end

        ST_WR_REQ: begin
          if (local_bus.ready) begin
            ack_q <= 1'b1;
            adr_q <= 32'({word_q, 2'b00});
          end
        end

        ST_RD_REQ: begin
          if (local_bus.ready) begin
            beats_q     <= chunk;
            remaining_q <= remaining_q - chunk;
          end
        end

        ST_RD_DATA: begin
          if (local_bus.rdata_valid) begin
            ack_q   <= 1'b1;
            rdata_q <= local_bus.rdata;
            adr_q   <= 32'({word_q, 2'b00});
            word_q  <= word_q + 1'b1;   // wraps modulo 2^ADDR_WIDTH
            beats_q <= beats_q - count_t'(1);
          end
        end

        default: ;
      endcase
    end
  end

  assign ack_o = ack_q;
  assign adr_o = adr_q;
  assign dat_o = rdata_q;

  assign local_bus.address    = word_q;
  assign local_bus.write_req  = wr_req;
  assign local_bus.read_req   = rd_req;
  assign local_bus.burstbegin = wr_req | rd_req;
  assign local_bus.size       = size;
  assign local_bus.be         = sel_q;
  assign local_bus.wdata      = wdata_q;

endmodule
